// File: rtl/immediate_sequencer_pkg.sv
// Shared encodings for the immediate sequencer: data width, extension modes and FSM states.
package immediate_sequencer_pkg;

  localparam int IMM_W = 16;

  typedef enum logic [1:0] {
    MODE_ZX4 = 2'b00,
    MODE_ZX8 = 2'b01,
    MODE_SX8 = 2'b10,
    MODE_ASM = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_COLLECT = 2'b01,
    ST_DONE    = 2'b10
  } seq_state_e;

endpackage

// File: rtl/immediate_extend.sv
// Combinational extension of the 8-bit instruction field into a 16-bit immediate.
module immediate_extend
  import immediate_sequencer_pkg::*;
(
  input  imm_mode_e        mode_i,
  input  logic [7:0]       field_i,
  output logic [IMM_W-1:0] ext_o
);

  always_comb begin
    ext_o = '0;
    case (mode_i)
      MODE_ZX4: ext_o = {12'h000, field_i[3:0]};
      MODE_ZX8: ext_o = {8'h00, field_i};
      MODE_SX8: ext_o = {{8{field_i[7]}}, field_i};
      default:  ext_o = '0;
    endcase
  end

endmodule

// File: rtl/immediate_sequencer.sv
// Produces a 16-bit immediate either by extending the instruction field in one cycle
// or by assembling four streamed nibbles, with timeout and abort handling.
module immediate_sequencer
  import immediate_sequencer_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [7:0]       Field,
  input  logic             NibbleValid,
  input  logic [3:0]       Nibble,
  input  logic             Abort,
  output logic             NibbleReady,
  output logic             Busy,
  output logic             ImmValid,
  output logic [IMM_W-1:0] Imm,
  output logic             Error
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  seq_state_e       state_q;
  logic [11:0]      acc_q;
  logic [1:0]       cnt_q;
  logic [7:0]       tmo_q;
  logic             ready_q;
  logic             busy_q;
  logic             vld_q;
  logic             err_q;
  logic [IMM_W-1:0] imm_q;
  logic [IMM_W-1:0] ext;

  immediate_extend u_extend (
    .mode_i  (imm_mode_e'(Mode)),
    .field_i (Field),
    .ext_o   (ext)
  );

  // Outputs are registered alongside the state they describe; defaults match IDLE.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      imm_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            busy_q <= 1'b1;
            if (imm_mode_e'(Mode) == MODE_ASM) begin
              acc_q   <= '0;
              cnt_q   <= '0;
              tmo_q   <= '0;
              ready_q <= 1'b1;
              state_q <= ST_COLLECT;
            end else begin
              imm_q   <= ext;
              vld_q   <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_COLLECT: begin
          // Abort outranks acceptance, completion and timeout in the same cycle.
          if (Abort) begin
            state_q <= ST_IDLE;
          end else if (NibbleValid) begin
            acc_q  <= {acc_q[7:0], Nibble};
            cnt_q  <= cnt_q + 2'd1;
            tmo_q  <= '0;
            busy_q <= 1'b1;
            if (cnt_q == 2'd3) begin
              imm_q   <= {acc_q, Nibble};
              vld_q   <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              ready_q <= 1'b1;
            end
          end else if (tmo_q == TMO_LAST) begin
            imm_q   <= '0;
            vld_q   <= 1'b1;
            err_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            tmo_q   <= tmo_q + 8'd1;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign NibbleReady = ready_q;
  assign Busy        = busy_q;
  assign ImmValid    = vld_q;
  assign Imm         = imm_q;
  assign Error       = err_q;

endmodule

// File: tb/tb_immediate_sequencer.sv
// Directed bench for immediate_sequencer, built with TIMEOUT=3 to exercise the timeout path.
module tb_immediate_sequencer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Mode = 2'b00;
  logic [7:0]  Field = 8'h00;
  logic        NibbleValid = 1'b0;
  logic [3:0]  Nibble = 4'h0;
  logic        Abort = 1'b0;
  logic        NibbleReady;
  logic        Busy;
  logic        ImmValid;
  logic [15:0] Imm;
  logic        Error;

  int n_checks = 0;
  int n_fail   = 0;

  immediate_sequencer #(.TIMEOUT(3)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Mode        (Mode),
    .Field       (Field),
    .NibbleValid (NibbleValid),
    .Nibble      (Nibble),
    .Abort       (Abort),
    .NibbleReady (NibbleReady),
    .Busy        (Busy),
    .ImmValid    (ImmValid),
    .Imm         (Imm),
    .Error       (Error)
  );

  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step();
    step();
    n_checks++; if (Imm !== 16'h0000) begin n_fail++; $display("FAIL rst_imm: got %h expected 0000", Imm); end
    n_checks++; if (ImmValid !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b expected 0", ImmValid); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", Busy); end
    n_checks++; if (NibbleReady !== 1'b0) begin n_fail++; $display("FAIL rst_rdy: got %b expected 0", NibbleReady); end
    n_checks++; if (Error !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", Error); end
    Reset = 1'b0;
    step();
  endtask

  task automatic test_zx4();
    Start = 1'b1; Mode = 2'b00; Field = 8'hAB;
    step();
    Start = 1'b0;
    n_checks++; if (ImmValid !== 1'b1) begin n_fail++; $display("FAIL zx4_vld: got %b expected 1", ImmValid); end
    n_checks++; if (Imm !== 16'h000B) begin n_fail++; $display("FAIL zx4_imm: got %h expected 000b", Imm); end
    n_checks++; if (Error !== 1'b0) begin n_fail++; $display("FAIL zx4_err: got %b expected 0", Error); end
    n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL zx4_busy: got %b expected 1", Busy); end
    n_checks++; if (NibbleReady !== 1'b0) begin n_fail++; $display("FAIL zx4_rdy: got %b expected 0", NibbleReady); end
    step();
    n_checks++; if (ImmValid !== 1'b0) begin n_fail++; $display("FAIL zx4_pulse: got %b expected 0", ImmValid); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL zx4_idle_busy: got %b expected 0", Busy); end
    n_checks++; if (Imm !== 16'h000B) begin n_fail++; $display("FAIL zx4_hold: got %h expected 000b", Imm); end
  endtask

  task automatic test_sx8_zx8();
    Start = 1'b1; Mode = 2'b10; Field = 8'h9C;
    step();
    Start = 1'b0;
    n_checks++; if (ImmValid !== 1'b1 || Imm !== 16'hFF9C) begin n_fail++; $display("FAIL sx8_neg: got vld=%b imm=%h expected vld=1 imm=ff9c", ImmValid, Imm); end
    step();
    Start = 1'b1; Mode = 2'b10; Field = 8'h7F;
    step();
    Start = 1'b0;
    n_checks++; if (ImmValid !== 1'b1 || Imm !== 16'h007F) begin n_fail++; $display("FAIL sx8_pos: got vld=%b imm=%h expected vld=1 imm=007f", ImmValid, Imm); end
    step();
    Start = 1'b1; Mode = 2'b01; Field = 8'h9C;
    step();
    Start = 1'b0;
    n_checks++; if (ImmValid !== 1'b1 || Imm !== 16'h009C) begin n_fail++; $display("FAIL zx8: got vld=%b imm=%h expected vld=1 imm=009c", ImmValid, Imm); end
    n_checks++; if (Error !== 1'b0) begin n_fail++; $display("FAIL zx8_err: got %b expected 0", Error); end
    step();
  endtask

  task automatic test_assemble_gaps();
    Start = 1'b1; Mode = 2'b11; Field = 8'h00;
    step();
    Start = 1'b0;
    n_checks++; if (NibbleReady !== 1'b1 || Busy !== 1'b1 || ImmValid !== 1'b0) begin n_fail++; $display("FAIL asm_enter: got rdy=%b busy=%b vld=%b expected 1 1 0", NibbleReady, Busy, ImmValid); end
    for (int i = 1; i <= 4; i++) begin
      NibbleValid = 1'b1; Nibble = 4'(i);
      step();
      NibbleValid = 1'b0;
      if (i < 4) begin
        n_checks++; if (ImmValid !== 1'b0 || NibbleReady !== 1'b1) begin n_fail++; $display("FAIL asm_nib%0d: got vld=%b rdy=%b expected 0 1", i, ImmValid, NibbleReady); end
        // A stray Start with a one-cycle mode must not disturb the collection.
        if (i == 2) begin Start = 1'b1; Mode = 2'b00; Field = 8'hFF; end
        step();
        Start = 1'b0;
        n_checks++; if (ImmValid !== 1'b0 || NibbleReady !== 1'b1) begin n_fail++; $display("FAIL asm_gap%0d: got vld=%b rdy=%b expected 0 1", i, ImmValid, NibbleReady); end
      end
    end
    n_checks++; if (ImmValid !== 1'b1) begin n_fail++; $display("FAIL asm_vld: got %b expected 1", ImmValid); end
    n_checks++; if (Imm !== 16'h1234) begin n_fail++; $display("FAIL asm_imm: got %h expected 1234", Imm); end
    n_checks++; if (Error !== 1'b0 || NibbleReady !== 1'b0) begin n_fail++; $display("FAIL asm_done_flags: got err=%b rdy=%b expected 0 0", Error, NibbleReady); end
    step();
    n_checks++; if (ImmValid !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL asm_after: got vld=%b busy=%b expected 0 0", ImmValid, Busy); end
  endtask

  task automatic test_timeout();
    Start = 1'b1; Mode = 2'b11;
    step();
    Start = 1'b0;
    NibbleValid = 1'b1; Nibble = 4'hA;
    step();
    Nibble = 4'hB;
    step();
    NibbleValid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      step();
      n_checks++; if (ImmValid !== 1'b0 || NibbleReady !== 1'b1) begin n_fail++; $display("FAIL tmo_idle%0d: got vld=%b rdy=%b expected 0 1", k, ImmValid, NibbleReady); end
    end
    step();
    n_checks++; if (ImmValid !== 1'b1) begin n_fail++; $display("FAIL tmo_vld: got %b expected 1", ImmValid); end
    n_checks++; if (Imm !== 16'h0000) begin n_fail++; $display("FAIL tmo_imm: got %h expected 0000", Imm); end
    n_checks++; if (Error !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", Error); end
    n_checks++; if (NibbleReady !== 1'b0) begin n_fail++; $display("FAIL tmo_rdy: got %b expected 0", NibbleReady); end
    step();
    n_checks++; if (Error !== 1'b0 || ImmValid !== 1'b0) begin n_fail++; $display("FAIL tmo_after: got err=%b vld=%b expected 0 0", Error, ImmValid); end
  endtask

  task automatic test_abort();
    Start = 1'b1; Mode = 2'b01; Field = 8'h5A;
    step();
    Start = 1'b0;
    step();
    Abort = 1'b1;
    step();
    Abort = 1'b0;
    n_checks++; if (Busy !== 1'b0 || Imm !== 16'h005A) begin n_fail++; $display("FAIL abort_idle_ignored: got busy=%b imm=%h expected 0 005a", Busy, Imm); end
    Start = 1'b1; Mode = 2'b11;
    step();
    Start = 1'b0;
    NibbleValid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      Nibble = 4'(i);
      step();
    end
    Nibble = 4'h4; Abort = 1'b1;
    step();
    NibbleValid = 1'b0; Abort = 1'b0;
    n_checks++; if (ImmValid !== 1'b0) begin n_fail++; $display("FAIL abort_vld: got %b expected 0", ImmValid); end
    n_checks++; if (Busy !== 1'b0 || NibbleReady !== 1'b0) begin n_fail++; $display("FAIL abort_state: got busy=%b rdy=%b expected 0 0", Busy, NibbleReady); end
    n_checks++; if (Imm !== 16'h005A) begin n_fail++; $display("FAIL abort_imm: got %h expected 005a", Imm); end
    step();
    n_checks++; if (ImmValid !== 1'b0) begin n_fail++; $display("FAIL abort_late_vld: got %b expected 0", ImmValid); end
  endtask

  task automatic test_back_to_back();
    Start = 1'b1; Mode = 2'b00; Field = 8'h07;
    step();
    Mode = 2'b01; Field = 8'hC3;
    n_checks++; if (ImmValid !== 1'b1 || Imm !== 16'h0007) begin n_fail++; $display("FAIL b2b_first: got vld=%b imm=%h expected 1 0007", ImmValid, Imm); end
    step();
    n_checks++; if (ImmValid !== 1'b0 || Imm !== 16'h0007) begin n_fail++; $display("FAIL b2b_done_start: got vld=%b imm=%h expected 0 0007", ImmValid, Imm); end
    step();
    Start = 1'b0;
    n_checks++; if (ImmValid !== 1'b1 || Imm !== 16'h00C3) begin n_fail++; $display("FAIL b2b_second: got vld=%b imm=%h expected 1 00c3", ImmValid, Imm); end
    step();
  endtask

  task automatic test_reset_mid();
    Start = 1'b1; Mode = 2'b11;
    step();
    Start = 1'b0;
    NibbleValid = 1'b1; Nibble = 4'h1;
    step();
    Nibble = 4'h2;
    step();
    Nibble = 4'h3; Reset = 1'b1;
    step();
    Reset = 1'b0; NibbleValid = 1'b0;
    n_checks++; if (Imm !== 16'h0000 || ImmValid !== 1'b0 || Busy !== 1'b0 || NibbleReady !== 1'b0 || Error !== 1'b0) begin n_fail++; $display("FAIL rstmid_outs: got imm=%h vld=%b busy=%b rdy=%b err=%b expected all 0", Imm, ImmValid, Busy, NibbleReady, Error); end
    step();
    n_checks++; if (ImmValid !== 1'b0 || Busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got vld=%b busy=%b expected 0 0", ImmValid, Busy); end
    Start = 1'b1; Mode = 2'b00; Field = 8'h3E;
    step();
    Start = 1'b0;
    n_checks++; if (ImmValid !== 1'b1 || Imm !== 16'h000E || Error !== 1'b0) begin n_fail++; $display("FAIL rstmid_zx4: got vld=%b imm=%h err=%b expected 1 000e 0", ImmValid, Imm, Error); end
    step();
    Start = 1'b1; Mode = 2'b10; Field = 8'hF5;
    step();
    Start = 1'b0; Reset = 1'b1;
    step();
    Reset = 1'b0;
    n_checks++; if (ImmValid !== 1'b0 || Imm !== 16'h0000 || Busy !== 1'b0) begin n_fail++; $display("FAIL rst_in_done: got vld=%b imm=%h busy=%b expected 0 0000 0", ImmValid, Imm, Busy); end
    step();
    n_checks++; if (ImmValid !== 1'b0) begin n_fail++; $display("FAIL rst_in_done_after: got %b expected 0", ImmValid); end
  endtask

  initial begin
    test_reset();
    test_zx4();
    test_sx8_zx8();
    test_assemble_gaps();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/immediate_sequencer.md
IMMEDIATE_SEQUENCER -- requirements
Module: immediate_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: consecutive COLLECT cycles without an accepted nibble before abandoning assembly; legal range 1..255.
REQ-002 SHALL have port Clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port Start, input, 1: request a new immediate; sampled only when Busy=0.
REQ-005 SHALL have port Mode, input, 2: 00 ZX4, 01 ZX8, 10 SX8, 11 ASSEMBLE; sampled with Start.
REQ-006 SHALL have port Field, input, 8: instruction immediate field; sampled with Start.
REQ-007 SHALL have port NibbleValid, input, 1: Nibble carries valid data this cycle.
REQ-008 SHALL have port Nibble, input, 4: next nibble of a 16-bit immediate, most significant first.
REQ-009 SHALL have port Abort, input, 1: cancel an ASSEMBLE in progress.
REQ-010 SHALL have port NibbleReady, output, 1: high only in COLLECT.
REQ-011 SHALL have port Busy, output, 1: high in COLLECT and DONE.
REQ-012 SHALL have port ImmValid, output, 1: one-cycle completion pulse, high only in DONE.
REQ-013 SHALL have port Imm, output, 16: result; holds its value between completions.
REQ-014 SHALL have port Error, output, 1: qualifies ImmValid; high when assembly timed out.

Function
REQ-015 SHALL implement states IDLE, COLLECT and DONE, all Moore outputs registered.
REQ-016 IDLE: Start=1 with Mode ZX4/ZX8/SX8 SHALL load Imm and go to DONE, giving ImmValid exactly 1 cycle after the Start edge.
REQ-017 ZX4 SHALL produce {12'h000, Field[3:0]}; ZX8 SHALL produce {8'h00, Field[7:0]}; SX8 SHALL produce {8{Field[7]}, Field[7:0]}.
REQ-018 IDLE: Start=1 with Mode=11 SHALL clear the accumulator, nibble count and timeout counter, then go to COLLECT.
REQ-019 COLLECT: a cycle with NibbleValid=1 SHALL accept Nibble, giving acc <= {acc[11:0], Nibble} and count <= count+1.
REQ-020 On the 4th accepted nibble, the block SHALL go to DONE with Imm = the assembled 16-bit value and Error=0.
REQ-021 The timeout counter SHALL clear on every accepted nibble and increment otherwise.
REQ-022 When the timeout counter reaches TIMEOUT, the block SHALL go to DONE with Imm=16'h0000 and Error=1.
REQ-023 COLLECT: Abort=1 SHALL return to IDLE next cycle without ImmValid, leaving Imm unchanged; Abort takes priority over nibble acceptance, completion and timeout in the same cycle.
REQ-024 Abort SHALL be ignored in IDLE and DONE.
REQ-025 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-026 Start asserted during DONE or COLLECT SHALL be ignored; the earliest new Start is accepted in the cycle after DONE.
REQ-027 Error SHALL be 0 whenever ImmValid=0.
REQ-028 Nibble and NibbleValid SHALL be ignored outside COLLECT.
REQ-029 An undefined state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-030 Reset=1 at a clock edge SHALL force IDLE and set Imm=16'h0000, Error=0, ImmValid=0, Busy=0, NibbleReady=0, and clear the accumulator and all counters.
REQ-031 Reset SHALL take priority over every other input, including mid-COLLECT and in DONE; no ImmValid follows a reset.

Structure
REQ-032 Mode encodings, state encoding and the 16-bit data width constant SHALL reside in the shared processor package.
REQ-033 Extension logic (ZX4/ZX8/SX8 mux) SHALL be one combinational sub-module, immediate_extend; sequencing, accumulator and counters stay in immediate_sequencer.

Verification
REQ-034 Case 1, ZX4: Start, Mode=00, Field=8'hAB -> next cycle ImmValid=1, Imm=16'h000B, Error=0.
REQ-035 Case 2, SX8: Start, Mode=10, Field=8'h9C -> Imm=16'hFF9C.
REQ-036 Case 3, ZX8: Start, Mode=01, Field=8'h9C -> Imm=16'h009C.
REQ-037 Case 4, ASSEMBLE with gaps: nibbles 1,2,3,4 with one idle cycle between each -> ImmValid one cycle after the 4th nibble, Imm=16'h1234, Error=0.
REQ-038 Case 5, timeout: ASSEMBLE with TIMEOUT=3 and 2 nibbles, then none -> DONE after 3 idle cycles, Imm=16'h0000, Error=1.
REQ-039 Case 6, Abort: Abort coincident with the 4th nibble -> IDLE, no ImmValid, Imm keeps its prior value; Start during DONE is ignored.
REQ-040 Case 7, Reset: Reset asserted after 2 nibbles -> all outputs 0 next cycle, and a following ZX4 request completes normally.
